// File: rtl/pwr_rail_seq_n.sv
// N-rail power sequencer: ordered power-up with per-rail power-good wait, reverse power-down, fault latching.
// Optional build macro PWR_SEQ_PG_DEGLITCH_EN adds a 4-sample low filter on runtime power-good drops.
module pwr_rail_seq_n #(
  parameter int NUM_RAILS  = 4,
  parameter int CLK_PER_MS = 2000,
  parameter int ON_DLY_MS  = 10,
  parameter int PG_TMO_MS  = 10000,
  parameter int OFF_DLY_MS = 10,
  parameter int DLY_W      = 16
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iPwr_Req,
  input  logic                 iAbort,
  input  logic                 iFault_Clr,
  input  logic [NUM_RAILS-1:0] iPWRGD,
  output logic [NUM_RAILS-1:0] oRail_EN,
  output logic                 oSeq_Done,
  output logic                 oFault,
  output logic [1:0]           oFault_Type,
  output logic [3:0]           oFault_Rail,
  output logic [3:0]           oDBG_FSM_curr
);

  localparam logic [3:0] ST_IDLE    = 4'h9;
  localparam logic [3:0] ST_ON_DLY  = 4'h7;
  localparam logic [3:0] ST_ON_PG   = 4'h5;
  localparam logic [3:0] ST_RUN     = 4'h0;
  localparam logic [3:0] ST_OFF_DLY = 4'h3;
  localparam logic [3:0] ST_FAULT   = 4'hF;

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0]        PRE_LAST  = PW'(CLK_PER_MS - 1);
  localparam logic [DLY_W-1:0]     ON_DLY    = DLY_W'(ON_DLY_MS);
  localparam logic [DLY_W-1:0]     PG_TMO    = DLY_W'(PG_TMO_MS);
  localparam logic [DLY_W-1:0]     OFF_DLY   = DLY_W'(OFF_DLY_MS);
  localparam logic [3:0]           LAST_RAIL = 4'(NUM_RAILS - 1);
  localparam logic [NUM_RAILS-1:0] RAIL_ONE  = {{(NUM_RAILS-1){1'b0}}, 1'b1};

  logic [3:0]           state_q, state_d;
  logic [PW-1:0]        presc_q;
  logic [DLY_W-1:0]     dly_q, dly_d;
  logic [3:0]           idx_q, idx_d;
  logic [NUM_RAILS-1:0] en_q, en_d;
  logic [1:0]           ftype_q, ftype_d;
  logic [3:0]           frail_q, frail_d;
  logic                 dly_clr;
  logic                 ms_tick;
  logic [NUM_RAILS-1:0] idx_oh;
  logic                 pg_cur;
  logic [NUM_RAILS-1:0] drop;
  logic [3:0]           drop_idx;
  logic [3:0]           hi_idx;

  assign ms_tick = (presc_q == PRE_LAST);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      presc_q <= '0;
    end else if (ms_tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

`ifdef PWR_SEQ_PG_DEGLITCH_EN
  logic [1:0] flt_q [NUM_RAILS];

  // A rail only counts as dropped once its power-good has been low for four RUN samples in a row.
  always_ff @(posedge iClk) begin
    for (int i = 0; i < NUM_RAILS; i++) begin
      if (!iRst_n || iPWRGD[i] || (state_q != ST_RUN)) begin
        flt_q[i] <= 2'd0;
      end else if (flt_q[i] != 2'd3) begin
        flt_q[i] <= flt_q[i] + 2'd1;
      end
    end
  end

  always_comb begin
    drop = '0;
    for (int i = 0; i < NUM_RAILS; i++) begin
      drop[i] = en_q[i] & ~iPWRGD[i] & (flt_q[i] == 2'd3);
    end
  end
`else
  assign drop = en_q & ~iPWRGD;
`endif

  assign idx_oh = RAIL_ONE << idx_q;
  assign pg_cur = |(iPWRGD & idx_oh);

  always_comb begin
    drop_idx = 4'd0;
    hi_idx   = 4'd0;
    for (int i = NUM_RAILS - 1; i >= 0; i--) begin
      if (drop[i]) drop_idx = 4'(i);
    end
    for (int i = 0; i < NUM_RAILS; i++) begin
      if (en_q[i]) hi_idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    ftype_d = ftype_q;
    frail_d = frail_q;
    dly_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iPwr_Req) begin
          state_d = ST_ON_DLY;
          idx_d   = 4'd0;
        end
      end
      ST_ON_DLY, ST_ON_PG: begin
        if ((state_q == ST_ON_PG) && !pg_cur && (dly_q == PG_TMO)) begin
          state_d = ST_FAULT;
          en_d    = '0;
          ftype_d = 2'd1;
          frail_d = idx_q;
        end else if (!iPwr_Req) begin
          // Unwind from the highest rail that is actually on; nothing on means nothing to sequence down.
          if (|en_q) begin
            state_d = ST_OFF_DLY;
            idx_d   = hi_idx;
            en_d    = en_q & ~(RAIL_ONE << hi_idx);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (state_q == ST_ON_DLY) begin
          if (dly_q == ON_DLY) begin
            en_d    = en_q | idx_oh;
            state_d = ST_ON_PG;
          end
        end else if (pg_cur) begin
          if (idx_q == LAST_RAIL) begin
            state_d = ST_RUN;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_ON_DLY;
          end
        end
      end
      ST_RUN: begin
        if (|drop) begin
          state_d = ST_FAULT;
          en_d    = '0;
          ftype_d = 2'd2;
          frail_d = drop_idx;
        end else if (!iPwr_Req) begin
          state_d = ST_OFF_DLY;
          idx_d   = LAST_RAIL;
          en_d    = en_q & ~(RAIL_ONE << LAST_RAIL);
        end
      end
      ST_OFF_DLY: begin
        if (dly_q == OFF_DLY) begin
          if (idx_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q - 4'd1;
            en_d    = en_q & ~(RAIL_ONE << (idx_q - 4'd1));
            dly_clr = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (iFault_Clr && !iPwr_Req && !iAbort) begin
          state_d = ST_IDLE;
          ftype_d = 2'd0;
          frail_d = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = '0;
      end
    endcase
    if (iAbort && (state_q != ST_FAULT)) begin
      state_d = ST_FAULT;
      en_d    = '0;
      ftype_d = 2'd3;
      frail_d = 4'd0;
    end
  end

  always_comb begin
    if (dly_clr || (state_d != state_q) || (state_q == ST_IDLE) ||
        (state_q == ST_RUN) || (state_q == ST_FAULT)) begin
      dly_d = '0;
    end else if (ms_tick) begin
      dly_d = dly_q + DLY_W'(1);
    end else begin
      dly_d = dly_q;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      idx_q   <= 4'd0;
      en_q    <= '0;
      ftype_q <= 2'd0;
      frail_q <= 4'd0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      ftype_q <= ftype_d;
      frail_q <= frail_d;
    end
  end

  assign oRail_EN      = en_q;
  assign oSeq_Done     = (state_q == ST_RUN);
  assign oFault        = (state_q == ST_FAULT);
  assign oFault_Type   = ftype_q;
  assign oFault_Rail   = frail_q;
  assign oDBG_FSM_curr = state_q;

endmodule

// File: tb/tb_pwr_rail_seq_n.sv
// Directed bench for pwr_rail_seq_n with 3 rails and short millisecond timing.
// A small rail model returns power-good 3 cycles after each enable unless held or forced low.
module tb_pwr_rail_seq_n;

  logic       iClk;
  logic       iRst_n;
  logic       iPwr_Req;
  logic       iAbort;
  logic       iFault_Clr;
  logic [2:0] iPWRGD;
  logic [2:0] oRail_EN;
  logic       oSeq_Done;
  logic       oFault;
  logic [1:0] oFault_Type;
  logic [3:0] oFault_Rail;
  logic [3:0] oDBG_FSM_curr;

  int         assertCount = 0;
  int         failCount   = 0;
  int         cyc         = 0;
  int         riseAt [3];
  int         fallAt [3];
  int         pgAt   [3];
  int         pgAge  [3];
  logic [2:0] prevEn, prevPg;
  logic [2:0] pgHold, pgForceLow;
  int         mark, ticks, gap;

  pwr_rail_seq_n #(
    .NUM_RAILS(3), .CLK_PER_MS(4), .ON_DLY_MS(2), .PG_TMO_MS(5), .OFF_DLY_MS(1), .DLY_W(16)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iPwr_Req(iPwr_Req), .iAbort(iAbort),
    .iFault_Clr(iFault_Clr), .iPWRGD(iPWRGD), .oRail_EN(oRail_EN),
    .oSeq_Done(oSeq_Done), .oFault(oFault), .oFault_Type(oFault_Type),
    .oFault_Rail(oFault_Rail), .oDBG_FSM_curr(oDBG_FSM_curr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic abort, input logic clr);
    iPwr_Req   = req;
    iAbort     = abort;
    iFault_Clr = clr;
  endtask

  task automatic refreshPg();
    for (int i = 0; i < 3; i++) begin
      iPWRGD[i] = (pgAge[i] >= 3) && !pgHold[i] && !pgForceLow[i];
      if (iPWRGD[i] && !prevPg[i]) pgAt[i] = cyc;
    end
    prevPg = iPWRGD;
  endtask

  task automatic stepClock();
    @(posedge iClk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (oRail_EN[i] && !prevEn[i]) riseAt[i] = cyc;
      if (!oRail_EN[i] && prevEn[i]) fallAt[i] = cyc;
      pgAge[i] = oRail_EN[i] ? ((pgAge[i] < 3) ? pgAge[i] + 1 : 3) : 0;
    end
    prevEn = oRail_EN;
    refreshPg();
  endtask

  task automatic clearRecords();
    for (int i = 0; i < 3; i++) begin
      riseAt[i] = 0;
      fallAt[i] = 0;
      pgAt[i]   = 0;
    end
  endtask

  task automatic powerUpToRun(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 200 && !oSeq_Done; k++) stepClock();
    checkOutput(tag, oSeq_Done, 1'b1);
  endtask

  initial begin
    iRst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    iPWRGD = 3'b000; prevEn = 3'b000; prevPg = 3'b000;
    pgHold = 3'b000; pgForceLow = 3'b000;
    for (int i = 0; i < 3; i++) pgAge[i] = 0;
    clearRecords();

    // Reset state
    repeat (3) stepClock();
    checkOutput("rst_en", oRail_EN, 3'b000);
    checkOutput("rst_done", oSeq_Done, 1'b0);
    checkOutput("rst_fault", oFault, 1'b0);
    checkOutput("rst_type", oFault_Type, 2'd0);
    checkOutput("rst_rail", oFault_Rail, 4'd0);
    checkOutput("rst_fsm", oDBG_FSM_curr, 4'h9);
    iRst_n = 1'b1;
    stepClock();

    // Nominal power-up then ordered power-down
    $display("[TB] nominal up/down");
    clearRecords();
    powerUpToRun("nom_reached_run");
    checkOutput("nom_fsm_run", oDBG_FSM_curr, 4'h0);
    checkOutput("nom_en_all", oRail_EN, 3'b111);
    checkOutput("nom_order01", riseAt[0] < riseAt[1], 1'b1);
    checkOutput("nom_order12", riseAt[1] < riseAt[2], 1'b1);
    gap = riseAt[1] - pgAt[0];
    checkOutput("nom_gap_pg0_en1", (gap >= 5) && (gap <= 12), 1'b1);
    gap = riseAt[2] - pgAt[1];
    checkOutput("nom_gap_pg1_en2", (gap >= 5) && (gap <= 12), 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    mark = cyc;
    for (int k = 0; k < 60 && oDBG_FSM_curr != 4'h9; k++) stepClock();
    checkOutput("nom_reached_idle", oDBG_FSM_curr, 4'h9);
    checkOutput("nom_en_off", oRail_EN, 3'b000);
    checkOutput("nom_fall2_first", fallAt[2], mark + 1);
    gap = fallAt[1] - fallAt[2];
    checkOutput("nom_gap_fall21", (gap >= 2) && (gap <= 5), 1'b1);
    checkOutput("nom_gap_fall10", fallAt[0] - fallAt[1], 4);

    // Power-good timeout on rail 1
    $display("[TB] PG timeout");
    clearRecords();
    pgHold = 3'b010;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 300 && !oFault; k++) stepClock();
    checkOutput("tmo_fault", oFault, 1'b1);
    gap = cyc - riseAt[1];
    checkOutput("tmo_latency", (gap >= 17) && (gap <= 21), 1'b1);
    checkOutput("tmo_type", oFault_Type, 2'd1);
    checkOutput("tmo_rail", oFault_Rail, 4'd1);
    checkOutput("tmo_en", oRail_EN, 3'b000);
    pgHold = 3'b000;
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClock();
    checkOutput("tmo_clr_fsm", oDBG_FSM_curr, 4'h9);
    checkOutput("tmo_clr_type", oFault_Type, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepClock();

    // Runtime power-good drop on rail 2
    $display("[TB] runtime drop");
    powerUpToRun("drop_reached_run");
`ifdef PWR_SEQ_PG_DEGLITCH_EN
    pgForceLow = 3'b100;
    refreshPg();
    stepClock();
    pgForceLow = 3'b000;
    refreshPg();
    repeat (3) stepClock();
    checkOutput("drop_glitch_nofault", oFault, 1'b0);
    checkOutput("drop_glitch_run", oDBG_FSM_curr, 4'h0);
`endif
    pgForceLow = 3'b100;
    refreshPg();
    ticks = 0;
    for (int k = 0; k < 10 && !oFault; k++) begin
      stepClock();
      ticks++;
    end
`ifdef PWR_SEQ_PG_DEGLITCH_EN
    checkOutput("drop_latency", ticks, 4);
`else
    checkOutput("drop_latency", ticks, 1);
`endif
    checkOutput("drop_type", oFault_Type, 2'd2);
    checkOutput("drop_rail", oFault_Rail, 4'd2);
    checkOutput("drop_en", oRail_EN, 3'b000);
    pgForceLow = 3'b000;
    refreshPg();
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepClock();

    // Abort while waiting for rail 0 power-good, then clear handshake
    $display("[TB] abort");
    pgHold = 3'b001;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 100 && oDBG_FSM_curr != 4'h5; k++) stepClock();
    checkOutput("abt_in_onpg", oDBG_FSM_curr, 4'h5);
    checkOutput("abt_en_before", oRail_EN, 3'b001);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepClock();
    checkOutput("abt_en", oRail_EN, 3'b000);
    checkOutput("abt_fault", oFault, 1'b1);
    checkOutput("abt_type", oFault_Type, 2'd3);
    checkOutput("abt_rail", oFault_Rail, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (2) stepClock();
    checkOutput("abt_clr_ignored", oDBG_FSM_curr, 4'hF);
    checkOutput("abt_type_held", oFault_Type, 2'd3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClock();
    checkOutput("abt_clr_fsm", oDBG_FSM_curr, 4'h9);
    checkOutput("abt_clr_type", oFault_Type, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    pgHold = 3'b000;
    stepClock();

    // Request withdrawn while waiting to enable rail 2
    $display("[TB] request drop mid power-up");
    clearRecords();
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 200 && !(oDBG_FSM_curr == 4'h7 && oRail_EN == 3'b011); k++) stepClock();
    checkOutput("mid_in_ondly2", {oDBG_FSM_curr, 1'b0, oRail_EN}, {4'h7, 1'b0, 3'b011});
    applyStimulus(1'b0, 1'b0, 1'b0);
    mark = cyc;
    for (int k = 0; k < 50 && oDBG_FSM_curr != 4'h9; k++) stepClock();
    checkOutput("mid_idle", oDBG_FSM_curr, 4'h9);
    checkOutput("mid_en_off", oRail_EN, 3'b000);
    checkOutput("mid_fall1_first", fallAt[1], mark + 1);
    gap = fallAt[0] - fallAt[1];
    checkOutput("mid_gap_fall10", (gap >= 2) && (gap <= 5), 1'b1);
    checkOutput("mid_rail2_never", riseAt[2], 0);

    // Synchronous reset from RUN
    $display("[TB] sync reset");
    powerUpToRun("srst_reached_run");
    iRst_n = 1'b0;
    #2;
    iRst_n = 1'b1;
    stepClock();
    checkOutput("srst_glitch_fsm", oDBG_FSM_curr, 4'h0);
    checkOutput("srst_glitch_en", oRail_EN, 3'b111);
    iRst_n = 1'b0;
    #2;
    checkOutput("srst_not_async", oRail_EN, 3'b111);
    stepClock();
    checkOutput("srst_en", oRail_EN, 3'b000);
    checkOutput("srst_fsm", oDBG_FSM_curr, 4'h9);
    checkOutput("srst_done", oSeq_Done, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    iRst_n = 1'b1;
    repeat (2) stepClock();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
